// File: rtl/ram_readback_tx.sv
// Read-back path: fetches a block of RAM words over req/gnt/rvalid and feeds them to the SPI TxData input in address order.
// Latency: start -> req_o next cycle; rvalid -> tx_valid_o next cycle; last pop -> done_o two cycles later.
// Backpressure: at most one read outstanding; no new request while the prefetch FIFO is full; SPI pops gate refills.
module ram_readback_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start_i,
  input  logic [31:0]      addr_ini_i,
  input  logic [CNT_W-1:0] size_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic             req_o,
  output logic             we_o,
  output logic [31:0]      addr_o,
  output logic [3:0]       b_en_o,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic             spi_done_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             tx_valid_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Transfer context
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remaining;

  // Prefetch FIFO storage and bookkeeping
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [FCNT_W-1:0] count;

  // Registered FIFO head presented to the SPI slave
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_nxt;
  logic             head_vld_q;
  logic             head_vld_nxt;

  logic underrun_q;
  logic done_q;

  // Strobes produced by the FSM decode
  logic start_acc;
  logic grant_acc;
  logic push;
  logic pop;
  logic done_set;
  logic fifo_empty;
  logic fifo_room;

  assign fifo_empty = (count == '0);
  assign fifo_room  = (count < FCNT_W'(DEPTH));
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // A pop only happens when a word is actually waiting; an empty pop is reported as underrun instead.
  assign pop = spi_done_i & ~fifo_empty;

  assign busy_o     = (state != S_IDLE);
  assign done_o     = done_q;
  assign underrun_o = underrun_q;
  assign we_o       = 1'b0;
  assign addr_o     = addr_q;
  assign b_en_o     = req_o ? 4'hF : 4'h0;
  assign tx_data_o  = head_q;
  assign tx_valid_o = head_vld_q;

  // State register
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_nxt = state;
    req_o     = 1'b0;
    start_acc = 1'b0;
    grant_acc = 1'b0;
    push      = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_nxt = (size_i == '0) ? S_DRAIN : S_REQ;
        end
      end
      S_REQ: begin
        // Count can only fall while in REQ, so once raised req_o holds until granted.
        req_o = fifo_room;
        if (fifo_room && gnt_i) begin
          grant_acc = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rvalid_i) begin
          push      = 1'b1;
          state_nxt = (remaining != '0) ? S_REQ : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          done_set  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address and word-count tracking for the active transfer
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (start_acc) begin
      addr_q    <= {addr_ini_i[31:2], 2'b00};
      remaining <= size_i;
    end else if (grant_acc) begin
      addr_q    <= addr_q + 32'd4;
      remaining <= remaining - 1'b1;
    end
  end

  // Sticky underrun flag and the one-cycle completion pulse
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_set;
      if (start_acc) begin
        underrun_q <= 1'b0;
      end else if (spi_done_i && fifo_empty && busy_o) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // FIFO storage, pointers and occupancy; a new start flushes anything left over
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (start_acc) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rdata_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Next head word: computed from the post-update FIFO contents so tx outputs come straight from flops
  always_comb begin
    head_nxt     = head_q;
    head_vld_nxt = head_vld_q;
    if (start_acc) begin
      head_nxt     = '0;
      head_vld_nxt = 1'b0;
    end else if (pop) begin
      if (count > FCNT_W'(1)) begin
        head_nxt     = mem[rd_ptr_inc];
        head_vld_nxt = 1'b1;
      end else if (push) begin
        // Last stored word leaves as the incoming word arrives; it becomes head directly.
        head_nxt     = rdata_i;
        head_vld_nxt = 1'b1;
      end else begin
        head_nxt     = '0;
        head_vld_nxt = 1'b0;
      end
    end else if (push && fifo_empty) begin
      head_nxt     = rdata_i;
      head_vld_nxt = 1'b1;
    end
  end

  // Head register driving tx_data_o / tx_valid_o
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      head_q     <= head_nxt;
      head_vld_q <= head_vld_nxt;
    end
  end

endmodule

// File: tb/tb_ram_readback_tx.sv
// Directed bench for ram_readback_tx: bus responder with configurable grant/latency, SPI pops from the tests.
// Inputs are driven 1 time unit after the rising edge; the responder acts 2 units after it.
// Each scenario task compares DUT outputs against hand-derived values inline.
module tb_ram_readback_tx;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] addr_ini_i = '0;
  logic [15:0] size_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        underrun_o;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  b_en_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic        spi_done_i = 1'b0;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls (written by the test sequence only)
  logic gnt_en = 1'b1;
  int   rv_lat = 1;

  // Responder state (written by the responder only)
  int          rv_wait = 0;
  logic [31:0] rv_addr = '0;
  logic [31:0] req_log [$];

  // Done pulse counter (written by the monitor only)
  int done_cnt = 0;

  ram_readback_tx dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .start_i    (start_i),
    .addr_ini_i (addr_ini_i),
    .size_i     (size_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .underrun_o (underrun_o),
    .req_o      (req_o),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .b_en_o     (b_en_o),
    .gnt_i      (gnt_i),
    .rvalid_i   (rvalid_i),
    .rdata_i    (rdata_i),
    .spi_done_i (spi_done_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] log_at(input int idx);
    if (idx < req_log.size()) return req_log[idx];
    return 32'hxxxx_xxxx;
  endfunction

  // Bus responder: grant when enabled, return read data rv_lat cycles after the grant
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      rvalid_i = 1'b0;
      rdata_i  = '0;
      if (rv_wait > 0) begin
        rv_wait = rv_wait - 1;
        if (rv_wait == 0) begin
          rvalid_i = 1'b1;
          rdata_i  = rd_model(rv_addr);
        end
      end
      gnt_i = gnt_en;
      if (req_o && gnt_i) begin
        rv_wait = rv_lat;
        rv_addr = addr_o;
        req_log.push_back(addr_o);
      end
    end
  end

  // Count done pulses
  initial begin
    forever begin
      @(posedge clk_sys);
      #3;
      if (done_o === 1'b1) done_cnt = done_cnt + 1;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] s);
    start_i    = 1'b1;
    addr_ini_i = a;
    size_i     = s;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_spi();
    spi_done_i = 1'b1;
    tick();
    spi_done_i = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_sys = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL rst_underrun: got %b want 0", underrun_o); end
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req_o); end
    n_cmp++; if (addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", addr_o); end
    n_cmp++; if (b_en_o !== 4'h0) begin n_bad++; $display("FAIL rst_ben: got %h want 0", b_en_o); end
    n_cmp++; if (we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", we_o); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_txv: got %b want 0", tx_valid_o); end
    n_cmp++; if (tx_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_txd: got %h want 0", tx_data_o); end
    rst_sys = 1'b0;
    tick();
  endtask

  // Scenario 1: three words, immediate grant, one-cycle read latency, SPI pop every 20 cycles
  task automatic test_basic();
    int  base;
    int  d0;
    bit  seen;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hDEAD_0100;
    exp_d[1] = 32'hDEAD_0104;
    exp_d[2] = 32'hDEAD_0108;
    gnt_en = 1'b1;
    rv_lat = 1;
    base = req_log.size();
    d0 = done_cnt;
    do_start(32'h0000_0100, 16'd3);
    n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL t1_req_lat: got %b want 1", req_o); end
    n_cmp++; if (addr_o !== 32'h100) begin n_bad++; $display("FAIL t1_addr0: got %h want 00000100", addr_o); end
    n_cmp++; if (b_en_o !== 4'hF) begin n_bad++; $display("FAIL t1_ben: got %h want f", b_en_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL t1_busy: got %b want 1", busy_o); end
    tick();
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL t1_req_wait: got %b want 0", req_o); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL t1_txv_early: got %b want 0", tx_valid_o); end
    tick();
    n_cmp++; if (tx_valid_o !== 1'b1) begin n_bad++; $display("FAIL t1_txv_lat: got %b want 1", tx_valid_o); end
    n_cmp++; if (addr_o !== 32'h104) begin n_bad++; $display("FAIL t1_addr1: got %h want 00000104", addr_o); end
    for (int j = 0; j < 3; j++) begin
      repeat (19) tick();
      n_cmp++; if (tx_data_o !== exp_d[j]) begin n_bad++; $display("FAIL t1_data%0d: got %h want %h", j, tx_data_o, exp_d[j]); end
      pulse_spi();
    end
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t1_done: got none want pulse"); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL t1_idle: got %b want 0", busy_o); end
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL t1_done_width: got %b want 0", done_o); end
    n_cmp++; if (req_log.size() - base !== 3) begin n_bad++; $display("FAIL t1_nreq: got %0d want 3", req_log.size() - base); end
    n_cmp++; if (log_at(base) !== 32'h100) begin n_bad++; $display("FAIL t1_log0: got %h want 00000100", log_at(base)); end
    n_cmp++; if (log_at(base + 1) !== 32'h104) begin n_bad++; $display("FAIL t1_log1: got %h want 00000104", log_at(base + 1)); end
    n_cmp++; if (log_at(base + 2) !== 32'h108) begin n_bad++; $display("FAIL t1_log2: got %h want 00000108", log_at(base + 2)); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL t1_done_cnt: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL t1_txv_end: got %b want 0", tx_valid_o); end
  endtask

  // Scenario 2: eight words with no SPI traffic; FIFO full stalls requests, each pop frees one read
  task automatic test_fifo_full();
    int  base;
    int  exp_n;
    bit  seen;
    logic [31:0] exp_w;
    gnt_en = 1'b1;
    rv_lat = 1;
    base = req_log.size();
    do_start(32'h0000_0200, 16'd8);
    repeat (40) tick();
    n_cmp++; if (req_log.size() - base !== 4) begin n_bad++; $display("FAIL t2_nreq_full: got %0d want 4", req_log.size() - base); end
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL t2_req_full: got %b want 0", req_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL t2_busy: got %b want 1", busy_o); end
    for (int j = 0; j < 8; j++) begin
      exp_w = rd_model(32'h200 + 32'(4 * j));
      n_cmp++; if (tx_valid_o !== 1'b1) begin n_bad++; $display("FAIL t2_txv%0d: got %b want 1", j, tx_valid_o); end
      n_cmp++; if (tx_data_o !== exp_w) begin n_bad++; $display("FAIL t2_data%0d: got %h want %h", j, tx_data_o, exp_w); end
      pulse_spi();
      if (j < 7) begin
        repeat (6) tick();
        exp_n = (j + 5 < 8) ? j + 5 : 8;
        n_cmp++; if (req_log.size() - base !== exp_n) begin n_bad++; $display("FAIL t2_nreq%0d: got %0d want %0d", j, req_log.size() - base, exp_n); end
      end
    end
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t2_done: got none want pulse"); end
    n_cmp++; if (log_at(base + 7) !== 32'h21C) begin n_bad++; $display("FAIL t2_log7: got %h want 0000021c", log_at(base + 7)); end
    tick();
  endtask

  // Scenario 3: grant withheld for 10 cycles with a stray start pulse in the middle
  task automatic test_gnt_stall();
    int  base;
    bit  seen;
    base = req_log.size();
    gnt_en = 1'b0;
    rv_lat = 1;
    do_start(32'h0000_0300, 16'd2);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (req_o !== 1'b1 || addr_o !== 32'h300) begin n_bad++; $display("FAIL t3_hold%0d: got req %b addr %h want 1 00000300", i, req_o, addr_o); end
      if (i == 4) begin
        start_i    = 1'b1;
        addr_ini_i = 32'h0000_0900;
        size_i     = 16'd7;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    start_i = 1'b0;
    gnt_en  = 1'b1;
    repeat (12) tick();
    n_cmp++; if (tx_data_o !== 32'hDEAD_0300) begin n_bad++; $display("FAIL t3_data0: got %h want dead0300", tx_data_o); end
    pulse_spi();
    n_cmp++; if (tx_data_o !== 32'hDEAD_0304) begin n_bad++; $display("FAIL t3_data1: got %h want dead0304", tx_data_o); end
    pulse_spi();
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t3_done: got none want pulse"); end
    n_cmp++; if (req_log.size() - base !== 2) begin n_bad++; $display("FAIL t3_nreq: got %0d want 2", req_log.size() - base); end
    n_cmp++; if (log_at(base + 1) !== 32'h304) begin n_bad++; $display("FAIL t3_log1: got %h want 00000304", log_at(base + 1)); end
    tick();
  endtask

  // Scenario 4: SPI pop before any data arrives, then a new start clears the flag
  task automatic test_underrun();
    bit seen;
    gnt_en = 1'b1;
    rv_lat = 6;
    do_start(32'h0000_0400, 16'd1);
    tick();
    pulse_spi();
    n_cmp++; if (underrun_o !== 1'b1) begin n_bad++; $display("FAIL t4_underrun: got %b want 1", underrun_o); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL t4_txv_empty: got %b want 0", tx_valid_o); end
    repeat (10) tick();
    n_cmp++; if (tx_valid_o !== 1'b1) begin n_bad++; $display("FAIL t4_txv: got %b want 1", tx_valid_o); end
    n_cmp++; if (tx_data_o !== 32'hDEAD_0400) begin n_bad++; $display("FAIL t4_data: got %h want dead0400", tx_data_o); end
    n_cmp++; if (underrun_o !== 1'b1) begin n_bad++; $display("FAIL t4_sticky: got %b want 1", underrun_o); end
    pulse_spi();
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t4_done: got none want pulse"); end
    tick();
    rv_lat = 1;
    do_start(32'h0000_0500, 16'd0);
    n_cmp++; if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL t4_clear: got %b want 0", underrun_o); end
    wait_done(seen);
    tick();
  endtask

  // Scenario 5: address wrap at the top of the space, then a zero-length transfer
  task automatic test_wrap_and_zero();
    int  base;
    bit  seen;
    gnt_en = 1'b1;
    rv_lat = 1;
    base = req_log.size();
    do_start(32'hFFFF_FFFE, 16'd2);
    n_cmp++; if (addr_o !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL t5_align: got %h want fffffffc", addr_o); end
    repeat (8) tick();
    n_cmp++; if (log_at(base + 1) !== 32'h0) begin n_bad++; $display("FAIL t5_wrap: got %h want 00000000", log_at(base + 1)); end
    n_cmp++; if (tx_data_o !== 32'h2152_FFFC) begin n_bad++; $display("FAIL t5_data0: got %h want 2152fffc", tx_data_o); end
    pulse_spi();
    n_cmp++; if (tx_data_o !== 32'hDEAD_0000) begin n_bad++; $display("FAIL t5_data1: got %h want dead0000", tx_data_o); end
    pulse_spi();
    wait_done(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL t5_done: got none want pulse"); end
    tick();
    base = req_log.size();
    do_start(32'h0000_0040, 16'd0);
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_bad++; $display("FAIL t5_zero_c1: got done %b busy %b want 0 1", done_o, busy_o); end
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL t5_zero_req: got %b want 0", req_o); end
    tick();
    n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_bad++; $display("FAIL t5_zero_c2: got done %b busy %b want 1 0", done_o, busy_o); end
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL t5_zero_c3: got %b want 0", done_o); end
    n_cmp++; if (req_log.size() - base !== 0) begin n_bad++; $display("FAIL t5_zero_nreq: got %0d want 0", req_log.size() - base); end
  endtask

  // Scenario 6: reset while a read is outstanding; the late read data must be dropped
  task automatic test_reset_mid();
    int d0;
    gnt_en = 1'b1;
    rv_lat = 5;
    d0 = done_cnt;
    do_start(32'h0000_0600, 16'd4);
    tick();
    rst_sys = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || req_o !== 1'b0 || b_en_o !== 4'h0) begin n_bad++; $display("FAIL t6_rst_ctl: got busy %b req %b ben %h want 0 0 0", busy_o, req_o, b_en_o); end
    n_cmp++; if (addr_o !== 32'h0 || tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL t6_rst_dat: got addr %h txv %b want 0 0", addr_o, tx_valid_o); end
    tick();
    tick();
    rst_sys = 1'b0;
    repeat (10) tick();
    n_cmp++; if (tx_valid_o !== 1'b0 || tx_data_o !== 32'h0) begin n_bad++; $display("FAIL t6_late_rvalid: got txv %b txd %h want 0 0", tx_valid_o, tx_data_o); end
    n_cmp++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin n_bad++; $display("FAIL t6_idle: got busy %b req %b want 0 0", busy_o, req_o); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL t6_no_done: got %0d want 0", done_cnt - d0); end
    rv_lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_gnt_stall();
    test_underrun();
    test_wrap_and_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
